// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI transmit encoder.
package midi_pkg;

   typedef enum logic [2:0] {
      EV_NOTE_OFF = 3'd0,
      EV_NOTE_ON  = 3'd1,
      EV_CTRL     = 3'd2,
      EV_PITCH    = 3'd3,
      EV_SYSEX3   = 3'd4
   } ev_type_e;

   // Each value names the byte the encoder is currently presenting on tx_data.
   typedef enum logic [2:0] {
      S_IDLE, S_STAT, S_D1, S_D2, S_D3, S_EOX
   } state_e;

   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_CTRL     = 4'hB;
   localparam logic [3:0] ST_PITCH    = 4'hE;

   localparam logic [7:0] SOX = 8'hF0;
   localparam logic [7:0] EOX = 8'hF7;

   function automatic logic [7:0] status_byte(input logic [2:0] t, input logic [3:0] ch);
      case (t)
         3'(EV_NOTE_OFF): status_byte = {ST_NOTE_OFF, ch};
         3'(EV_NOTE_ON):  status_byte = {ST_NOTE_ON, ch};
         3'(EV_CTRL):     status_byte = {ST_CTRL, ch};
         3'(EV_PITCH):    status_byte = {ST_PITCH, ch};
         3'(EV_SYSEX3):   status_byte = SOX;
         default:         status_byte = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] data_byte(input logic [7:0] b);
      data_byte = {1'b0, b[6:0]};
   endfunction

endpackage

// File: rtl/midi_rs_timer.sv
// Saturating idle counter; expired flags the cycle the count reaches TIMEOUT.
module midi_rs_timer #(
   parameter int TIMEOUT = 25000000,
   parameter int TW      = 25
) (
   input  logic sys_clk,
   input  logic iRST,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && cnt_q != LIMIT)
         cnt_d = cnt_q + 1'b1;
   end

   // Looking at the next count lets the owner drop running status on the
   // same edge the limit is reached.
   assign expired = (TIMEOUT != 0) && (cnt_d == LIMIT);

   always_ff @(posedge sys_clk) begin
      if (iRST) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/midi_encoder.sv
// Serialises synth events into MIDI bytes with running-status compression.
module midi_encoder
   import midi_pkg::*;
#(
   parameter int RUNNING_STATUS = 1,
   parameter int RS_TIMEOUT     = 25000000,
   parameter int TW             = 25
) (
   input  logic       sys_clk,
   input  logic       iRST,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [2:0] ev_type,
   input  logic [3:0] ev_chan,
   input  logic [7:0] ev_d1,
   input  logic [7:0] ev_d2,
   input  logic [7:0] ev_d3,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       rs_active,
   output logic       ev_err
);
   state_e     state_q;
   logic       sysex_q;
   logic [7:0] d1_q, d2_q, d3_q, stat_q, last_status_q;
   logic [7:0] tx_data_q;
   logic       tx_valid_q, rs_active_q, ev_err_q;
   logic       tx_xfer, expired;
   logic [7:0] stat;

   assign stat    = status_byte(ev_type, ev_chan);
   assign tx_xfer = tx_valid_q && tx_ready;

   midi_rs_timer #(.TIMEOUT(RS_TIMEOUT), .TW(TW)) u_timer (
      .sys_clk (sys_clk),
      .iRST    (iRST),
      .clear   (tx_xfer),
      .enable  (1'b1),
      .expired (expired)
   );

   always_ff @(posedge sys_clk) begin
      if (iRST) begin
         state_q       <= S_IDLE;
         sysex_q       <= 1'b0;
         d1_q          <= '0;
         d2_q          <= '0;
         d3_q          <= '0;
         stat_q        <= '0;
         last_status_q <= '0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         rs_active_q   <= 1'b0;
         ev_err_q      <= 1'b0;
      end else begin
         ev_err_q <= 1'b0;
         if (expired) rs_active_q <= 1'b0;
         case (state_q)
            S_IDLE: if (ev_valid) begin
               sysex_q <= (ev_type == 3'(EV_SYSEX3));
               d1_q    <= ev_d1;
               d2_q    <= ev_d2;
               d3_q    <= ev_d3;
               stat_q  <= stat;
               if (ev_type > 3'(EV_SYSEX3)) begin
                  ev_err_q <= 1'b1;
               end else if (ev_type != 3'(EV_SYSEX3) && RUNNING_STATUS != 0 &&
                            rs_active_q && !expired && stat == last_status_q) begin
                  // A timeout landing on this edge forces the full status byte.
                  state_q    <= S_D1;
                  tx_data_q  <= data_byte(ev_d1);
                  tx_valid_q <= 1'b1;
               end else begin
                  state_q    <= S_STAT;
                  tx_data_q  <= stat;
                  tx_valid_q <= 1'b1;
               end
            end
            S_STAT: if (tx_xfer) begin
               if (sysex_q) begin
                  rs_active_q <= 1'b0;
               end else begin
                  last_status_q <= stat_q;
                  rs_active_q   <= (RUNNING_STATUS != 0);
               end
               state_q   <= S_D1;
               tx_data_q <= data_byte(d1_q);
            end
            S_D1: if (tx_xfer) begin
               state_q   <= S_D2;
               tx_data_q <= data_byte(d2_q);
            end
            S_D2: if (tx_xfer) begin
               if (sysex_q) begin
                  state_q   <= S_D3;
                  tx_data_q <= data_byte(d3_q);
               end else begin
                  state_q    <= S_IDLE;
                  tx_valid_q <= 1'b0;
               end
            end
            S_D3: if (tx_xfer) begin
               state_q   <= S_EOX;
               tx_data_q <= EOX;
            end
            S_EOX: if (tx_xfer) begin
               state_q    <= S_IDLE;
               tx_valid_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ev_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign rs_active = rs_active_q;
   assign ev_err    = ev_err_q;

endmodule

// File: tb/tb_midi_encoder.sv
// Randomised scoreboard bench for midi_encoder with a message-level reference model.
module tb_midi_encoder;
   localparam int TO = 16;

   logic       sys_clk = 1'b0;
   logic       iRST = 1'b1;
   logic       ev_valid = 1'b0;
   logic [2:0] ev_type = '0;
   logic [3:0] ev_chan = '0;
   logic [7:0] ev_d1 = '0, ev_d2 = '0, ev_d3 = '0;
   logic       tx_ready = 1'b1;
   logic       ev_ready, tx_valid, busy, rs_active, ev_err;
   logic [7:0] tx_data;

   midi_encoder #(.RUNNING_STATUS(1), .RS_TIMEOUT(TO), .TW(5)) dut (
      .sys_clk(sys_clk), .iRST(iRST), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_type(ev_type), .ev_chan(ev_chan), .ev_d1(ev_d1), .ev_d2(ev_d2), .ev_d3(ev_d3),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
      .rs_active(rs_active), .ev_err(ev_err)
   );

   always #5 sys_clk = ~sys_clk;

   int tests = 0, fails = 0;
   int tx_mode = 0;
   logic [7:0] exp_q[$];

   // Model state: running status as the MIDI rules define it.
   bit         m_rs = 0;
   logic [7:0] m_last = '0;
   int         quiet = 0;
   bit         err_exp = 0, lat_exp = 0, rst_chk = 0, stall_prev = 0;
   logic [7:0] stall_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] nibble(input logic [2:0] t);
      case (t)
         3'd0: nibble = 4'h8;
         3'd1: nibble = 4'h9;
         3'd2: nibble = 4'hB;
         default: nibble = 4'hE;
      endcase
   endfunction

   always @(posedge sys_clk) begin
      #1;
      case (tx_mode)
         0: tx_ready = 1'b1;
         1: tx_ready = ~tx_ready;
         default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Inputs are stable from posedge+1 until the next posedge, so the negedge
   // sees exactly the handshakes that the coming edge will perform.
   always @(negedge sys_clk) begin
      bit acc, xfer;
      logic [7:0] b, st;
      check("rs_active", {31'd0, rs_active}, {31'd0, m_rs});
      check("ev_err", {31'd0, ev_err}, {31'd0, err_exp});
      if (err_exp) begin
         check("ev_ready after invalid", {31'd0, ev_ready}, 32'd1);
         check("no tx after invalid", {31'd0, tx_valid}, 32'd0);
      end
      if (lat_exp) check("tx_valid latency", {31'd0, tx_valid}, 32'd1);
      if (rst_chk) begin
         check("reset tx_valid", {31'd0, tx_valid}, 32'd0);
         check("reset busy", {31'd0, busy}, 32'd0);
         check("reset ev_ready", {31'd0, ev_ready}, 32'd1);
      end
      if (stall_prev) begin
         check("stall tx_valid", {31'd0, tx_valid}, 32'd1);
         check("stall tx_data", {24'd0, tx_data}, {24'd0, stall_data});
      end
      err_exp = 0; lat_exp = 0; rst_chk = 0;
      if (iRST) begin
         m_rs = 0; quiet = 0; stall_prev = 0; rst_chk = 1;
         exp_q.delete();
      end else begin
         acc  = ev_valid && ev_ready;
         xfer = tx_valid && tx_ready;
         stall_prev = tx_valid && !tx_ready;
         stall_data = tx_data;
         // Output side: pop and compare every transferred byte.
         if (xfer) begin
            quiet = 0;
            if (exp_q.size() == 0) begin
               check("unexpected tx byte", {24'd0, tx_data}, 32'h100);
            end else begin
               b = exp_q.pop_front();
               check("tx byte", {24'd0, tx_data}, {24'd0, b});
               if (b == 8'hF0) m_rs = 0;
               else if (b[7] && b != 8'hF7) begin m_rs = 1; m_last = b; end
            end
         end else begin
            if (quiet < TO) quiet++;
            if (quiet >= TO) m_rs = 0;
         end
         // Input side: turn each accepted event into the bytes it should produce.
         if (acc) begin
            if (ev_type > 3'd4) err_exp = 1;
            else begin
               lat_exp = 1;
               if (ev_type == 3'd4) begin
                  exp_q.push_back(8'hF0);
                  exp_q.push_back(ev_d1 & 8'h7F);
                  exp_q.push_back(ev_d2 & 8'h7F);
                  exp_q.push_back(ev_d3 & 8'h7F);
                  exp_q.push_back(8'hF7);
               end else begin
                  st = {nibble(ev_type), ev_chan};
                  if (!(m_rs && st == m_last)) exp_q.push_back(st);
                  exp_q.push_back(ev_d1 & 8'h7F);
                  exp_q.push_back(ev_d2 & 8'h7F);
               end
            end
         end
      end
   end

   task automatic send(input logic [2:0] t, input logic [3:0] c,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
      int n = 0;
      @(posedge sys_clk); #1;
      ev_type = t; ev_chan = c; ev_d1 = a; ev_d2 = b; ev_d3 = d; ev_valid = 1'b1;
      forever begin
         @(negedge sys_clk);
         if (ev_ready) break;
         n++;
         if (n > 2000) begin
            check("ev_ready timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge sys_clk); #1;
      ev_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      forever begin
         @(negedge sys_clk);
         if (!busy && !tx_valid && exp_q.size() == 0) break;
         n++;
         if (n > 2000) begin
            check("idle timeout", 32'd0, 32'd1);
            break;
         end
      end
   endtask

   initial begin
      int n;
      logic [2:0] t;
      int r;
      repeat (3) @(posedge sys_clk);
      #1 iRST = 1'b0;
      @(negedge sys_clk);
      check("reset tx_data", {24'd0, tx_data}, 32'd0);

      // Running status on repeated note on.
      send(3'd1, 4'd0, 8'h3C, 8'h64, 8'h00);
      send(3'd1, 4'd0, 8'h3E, 8'h50, 8'h00);
      wait_idle();
      // Status changes across channel / type.
      send(3'd1, 4'd0, 8'h3C, 8'h64, 8'h00);
      send(3'd2, 4'd2, 8'h07, 8'h7F, 8'h00);
      send(3'd3, 4'd2, 8'h00, 8'h40, 8'h00);
      wait_idle();
      // Timeout forces a fresh status byte.
      send(3'd1, 4'd1, 8'h40, 8'h40, 8'h00);
      wait_idle();
      repeat (20) @(posedge sys_clk);
      send(3'd1, 4'd1, 8'h41, 8'h40, 8'h00);
      wait_idle();
      // Sysex under backpressure, then a note that must resend status.
      tx_mode = 1;
      send(3'd4, 4'd0, 8'h01, 8'h02, 8'h83);
      wait_idle();
      tx_mode = 0;
      send(3'd1, 4'd0, 8'h3C, 8'h64, 8'h00);
      wait_idle();
      // Invalid type, then masking of data bytes.
      send(3'd7, 4'd0, 8'h11, 8'h22, 8'h33);
      repeat (3) @(posedge sys_clk);
      send(3'd0, 4'd15, 8'hBC, 8'hFF, 8'h00);
      wait_idle();
      // Reset right after the status byte goes out.
      send(3'd1, 4'd0, 8'h3C, 8'h64, 8'h00);
      n = 0;
      forever begin
         if (tx_valid && tx_ready && tx_data == 8'h90) break;
         n++;
         if (n > 100) begin check("status byte wait", 32'd0, 32'd1); break; end
         @(negedge sys_clk);
      end
      @(posedge sys_clk); #1 iRST = 1'b1;
      @(posedge sys_clk); #1 iRST = 1'b0;
      send(3'd1, 4'd0, 8'h3C, 8'h64, 8'h00);
      wait_idle();

      // Random traffic with random backpressure and gaps around the timeout.
      tx_mode = 2;
      repeat (150) begin
         repeat ($urandom_range(0, 20)) @(posedge sys_clk);
         r = $urandom_range(0, 15);
         t = (r < 13) ? 3'(r % 5) : 3'(5 + r - 13);
         send(t, 4'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      wait_idle();
      check("scoreboard drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/midi_encoder.md
Name: midi_encoder

Overview:
Transmit-side MIDI message builder. It takes one synth-side event per handshake (note on/off, control change, pitch bend, 3-byte sysex) and serialises it into MIDI bytes for the UART transmitter. Running-status compression is applied, with a timeout that forces the status byte to be resent. The byte stream it produces is the format the synth's MIDI receive path already parses.

Parameters:
RUNNING_STATUS, 1, 1 = omit repeated status bytes; 0 = always send status.
RS_TIMEOUT, 25000000, sys_clk cycles without a transferred byte before running status is invalidated; 0 disables the timeout.
TW, 25, timeout counter width; must satisfy 2**TW > RS_TIMEOUT.

Ports:
sys_clk  in  1  clock
iRST  in  1  reset
ev_valid  in  1  event offered
ev_ready  out  1  encoder can accept an event
ev_type  in  3  0 note off, 1 note on, 2 ctrl, 3 pitch, 4 sysex3; others invalid
ev_chan  in  4  MIDI channel
ev_d1  in  8  key / controller / pitch LSB / sysex byte 0
ev_d2  in  8  velocity / value / pitch MSB / sysex byte 1
ev_d3  in  8  sysex byte 2 (ignored for other types)
tx_data  out  8  byte to UART
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART accepts the byte
busy  out  1  message in progress
rs_active  out  1  running status currently valid
ev_err  out  1  one-cycle pulse when an invalid ev_type is accepted

Behaviour:
- One clock, sys_clk. Reset is synchronous, active-high (iRST).
- Reset values: ev_ready=1, tx_valid=0, tx_data=0, busy=0, rs_active=0, ev_err=0, last_status=0, timeout counter=0, FSM in IDLE.
- Event transfer occurs on ev_valid && ev_ready. ev_ready is 1 only in IDLE.
- On transfer, latch all event fields.
- Byte transfer occurs on tx_valid && tx_ready. tx_data and tx_valid hold stable until the transfer; tx_valid never drops without a transfer except on reset.
- Status byte construction:
  - note off = {4'h8, chan}
  - note on = {4'h9, chan}
  - ctrl = {4'hB, chan}
  - pitch = {4'hE, chan}
  - sysex uses 8'hF0 … 8'hF7
- All data bytes are sent with bit 7 forced to 0.
- FSM states: IDLE, STAT, D1, D2, D3, EOX.
- Transitions from IDLE on event transfer:
  - Invalid type: pulse ev_err the next cycle, stay in IDLE, send no bytes, leave running status unchanged.
  - Sysex: go to STAT with F0.
  - Channel message with RUNNING_STATUS && rs_active && status==last_status: go to D1 (status skipped).
  - Otherwise: go to STAT.
- Byte sequence:
  - STAT→D1 after transfer.
  - D1→D2 after transfer.
  - D2→IDLE (channel message) or D2→D3 (sysex).
  - D3→EOX after transfer.
  - EOX (F7)→IDLE after transfer.
- Latency: tx_valid rises the cycle after event transfer. ev_ready rises the cycle after the last byte transfer.
- Running status:
  - After a channel status byte transfers: last_status←status, rs_active←1.
  - After the F0 byte transfers: rs_active←0.
- Timeout counter:
  - Clears on every byte transfer.
  - Otherwise increments, saturating at RS_TIMEOUT.
  - At RS_TIMEOUT==counter (RS_TIMEOUT≠0): rs_active←0.
- Simultaneous events:
  - A timeout in the same cycle as an event transfer: the timeout wins, and the status byte is sent.
  - A timeout while a message is in progress cannot occur, because tx stalls only hold the counter? No — the counter runs during a stall. A timeout during a stall clears rs_active, and the rest of the current message is still sent unchanged.
- RUNNING_STATUS=0: rs_active stays 0 permanently.
- Reset mid-message: the message is abandoned and tx_valid=0 from the next cycle. rs_active=0, so the next message carries a full status byte and the receiver resynchronises.
- busy = (state != IDLE).

Decomposition:
- Shared package midi_pkg:
  - ev_type enum: EV_NOTE_OFF, EV_NOTE_ON, EV_CTRL, EV_PITCH, EV_SYSEX3.
  - Status-nibble constants: ST_NOTE_OFF=4'h8, ST_NOTE_ON=4'h9, ST_CTRL=4'hB, ST_PITCH=4'hE.
  - Byte constants: SOX=8'hF0, EOX=8'hF7.
  - FSM state enum.
- One sub-module, midi_rs_timer: saturating timeout counter with inputs clear and enable, and output expired.

Test Plan:
- Basic note on with running status: note on ch0, d1=8'h3C, d2=8'h64, tx_ready=1 → bytes 90 3C 64. Then note on ch0 3E 50 → bytes 3E 50 only; rs_active=1.
- Status change: note on ch0 3C 64, then ctrl ch2 07 7F → 90 3C 64 B2 07 7F. Then pitch ch2 00 40 → E2 00 40.
- Timeout: run with RS_TIMEOUT=16. Note on ch1 40 40, idle 20 cycles, then note on ch1 41 40 → 91 40 40 … 91 41 40; rs_active falls exactly 16 cycles after the last transfer.
- Sysex and backpressure: sysex3 d1=01 d2=02 d3=83 with tx_ready toggling 1/0 → F0 01 02 03 F7, each byte stable while stalled. A following note on ch0 → status 90 resent.
- Invalid type and masking: ev_type=7 → ev_err pulse, no bytes, ev_ready stays 1. Note off ch15 d1=8'hBC d2=8'hFF → 8F 3C 7F.
- Reset mid-message: assert iRST after the 90 byte transfers → tx_valid=0 next cycle. After release, note on ch0 3C 64 → full 90 3C 64.
